// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad decoder.
// Vectors are active-low: a zero bit is a pressed key.
package keypad_pkg;

    localparam int KEY_W  = 16;
    localparam int CODE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        HOLD,
        MULTI
    } kp_state_e;

    function automatic logic [CODE_W-1:0] onehot0_to_code(
        input logic [KEY_W-1:0] v
    );
        logic [CODE_W-1:0] c;
        c = '0;
        for (int i = 0; i < KEY_W; i++) begin
            if (!v[i]) c = CODE_W'(i);
        end
        return c;
    endfunction

    function automatic logic zero_count_gt1(
        input logic [KEY_W-1:0] v
    );
        int n;
        n = 0;
        for (int i = 0; i < KEY_W; i++) begin
            if (!v[i]) n++;
        end
        return (n > 1);
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Synchroniser, sample-tick divider and debounce filter for
// the raw scanner vector.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int SAMPLE_DIV = 50000,
    parameter int DEB_CNT    = 10
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [KEY_W-1:0] key_n,
    output logic [KEY_W-1:0] deb_vec,
    output logic             tick,
    output logic             none_acc
);

    localparam int DIV_W  = $clog2(SAMPLE_DIV);
    localparam int STAB_W = $clog2(DEB_CNT + 1);

    logic [KEY_W-1:0]  sync1;
    logic [KEY_W-1:0]  sync2;
    logic [KEY_W-1:0]  sample;
    logic [DIV_W-1:0]  div;
    logic [STAB_W-1:0] stab_cnt;
    logic [STAB_W-1:0] stab_nxt;
    logic              accept;

    assign tick = (div == DIV_W'(SAMPLE_DIV - 1));

    always_comb begin
        stab_nxt = '0;
        if (sync2 == sample) begin
            if (stab_cnt == STAB_W'(DEB_CNT))
                stab_nxt = stab_cnt;
            else
                stab_nxt = stab_cnt + 1'b1;
        end
    end

    // stab_cnt counts repeats of a sample: DEB_CNT-1 repeats
    // means DEB_CNT identical samples in a row.
    assign accept   = tick && (stab_nxt >= STAB_W'(DEB_CNT - 1));
    assign none_acc = accept && (&sync2);

    always_ff @(posedge clk) begin
        if (RST) begin
            sync1    <= '1;
            sync2    <= '1;
            sample   <= '1;
            deb_vec  <= '1;
            div      <= '0;
            stab_cnt <= '0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            div   <= tick ? '0 : div + 1'b1;
            if (tick) begin
                sample   <= sync2;
                stab_cnt <= stab_nxt;
                if (accept) deb_vec <= sync2;
            end
        end
    end

endmodule

// File: rtl/keypad_decoder.sv
// Keypad press detector: single-key strobe with auto-repeat,
// roll-over lock-out and a re-arm requirement after reset.
module keypad_decoder
    import keypad_pkg::*;
#(
    parameter int SAMPLE_DIV = 50000,
    parameter int DEB_CNT    = 10,
    parameter int REPEAT_DLY = 500,
    parameter int REPEAT_PER = 100,
    parameter int REPEAT_EN  = 1
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [KEY_W-1:0]  key_n,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_down,
    output logic              key_multi
);

    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ?
                             REPEAT_DLY : REPEAT_PER;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    kp_state_e         state;
    kp_state_e         state_nxt;
    logic [KEY_W-1:0]  deb_vec;
    logic              tick;
    logic              none_acc;
    logic              armed;
    logic              is_none;
    logic              is_multi;
    logic              is_one;
    logic              same_key;
    logic [CODE_W-1:0] k;
    logic [RPT_W-1:0]  rpt_cnt;
    logic [RPT_W-1:0]  rpt_inc;
    logic [RPT_W-1:0]  rpt_lim;
    logic              first_rpt;
    logic              rpt_fire;

    keypad_debounce #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .DEB_CNT    (DEB_CNT)
    ) u_deb (
        .clk      (clk),
        .RST      (RST),
        .key_n    (key_n),
        .deb_vec  (deb_vec),
        .tick     (tick),
        .none_acc (none_acc)
    );

    assign is_none  = &deb_vec;
    assign is_multi = zero_count_gt1(deb_vec);
    assign is_one   = !is_none && !is_multi;
    assign k        = onehot0_to_code(deb_vec);
    assign same_key = is_one && (k == key_code);

    assign rpt_inc  = rpt_cnt + 1'b1;
    assign rpt_lim  = first_rpt ? RPT_W'(REPEAT_DLY)
                                : RPT_W'(REPEAT_PER);
    assign rpt_fire = (REPEAT_EN != 0) && (state == HOLD) &&
                      tick && same_key && (rpt_inc == rpt_lim);

    always_ff @(posedge clk) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // IDLE waits for an accepted all-released vector first, so a
    // key held across reset never strobes.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (armed) begin
                    if (is_multi)    state_nxt = MULTI;
                    else if (is_one) state_nxt = PRESS;
                end
            end
            PRESS: state_nxt = HOLD;
            HOLD: begin
                if (is_none)        state_nxt = IDLE;
                else if (!same_key) state_nxt = MULTI;
            end
            MULTI: begin
                if (is_none) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        key_valid = 1'b0;
        key_down  = 1'b0;
        key_multi = 1'b0;
        unique case (state)
            PRESS: key_valid = 1'b1;
            HOLD: begin
                key_down  = 1'b1;
                key_valid = rpt_fire;
            end
            MULTI:   key_multi = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            key_code  <= '0;
            rpt_cnt   <= '0;
            first_rpt <= 1'b1;
            armed     <= 1'b0;
        end else begin
            if (none_acc) armed <= 1'b1;
            if (state == IDLE && state_nxt == PRESS) key_code <= k;
            if (state == PRESS || rpt_fire) begin
                rpt_cnt   <= '0;
                first_rpt <= (state == PRESS);
            end else if (state == HOLD && tick && REPEAT_EN != 0) begin
                rpt_cnt <= rpt_inc;
            end
        end
    end

endmodule

// File: tb/tb_keypad_decoder.sv
// Bench for keypad_decoder: directed scenarios plus random
// key traffic, checked every cycle against a behavioural model.
module tb_keypad_decoder;

    localparam int SD = 4;
    localparam int DC = 3;
    localparam int RD = 5;
    localparam int RP = 2;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] key_n = 16'hFFFF;
    logic [3:0]  code1, code0;
    logic        valid1, valid0;
    logic        down1, down0;
    logic        multi1, multi0;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;
    int sc1 = 0;
    int sc0 = 0;

    always #5 clk = ~clk;

    keypad_decoder #(
        .SAMPLE_DIV (SD), .DEB_CNT (DC),
        .REPEAT_DLY (RD), .REPEAT_PER (RP), .REPEAT_EN (1)
    ) dut (
        .clk (clk), .RST (RST), .key_n (key_n),
        .key_code (code1), .key_valid (valid1),
        .key_down (down1), .key_multi (multi1)
    );

    keypad_decoder #(
        .SAMPLE_DIV (SD), .DEB_CNT (DC),
        .REPEAT_DLY (RD), .REPEAT_PER (RP), .REPEAT_EN (0)
    ) dut0 (
        .clk (clk), .RST (RST), .key_n (key_n),
        .key_code (code0), .key_valid (valid0),
        .key_down (down0), .key_multi (multi0)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      tag, got, exp, $time);
    endtask

    function automatic int zeros(input logic [15:0] v);
        return $countones(~v);
    endfunction

    function automatic int zero_idx(input logic [15:0] v);
        for (int i = 0; i < 16; i++)
            if (!v[i]) return i;
        return -1;
    endfunction

    function automatic bit due(input int n);
        if (n == RD) return 1'b1;
        return (n > RD) && ((n - RD) % RP == 0);
    endfunction

    // Model: run-length debouncing, and a repeat schedule
    // counted in ticks since the press strobe.
    logic [15:0] m_s1 = '1, m_s2 = '1, m_samp = '1, m_deb = '1;
    int m_div = 0, m_run = 1, m_code = 0, m_ticks = 0;
    bit m_armed = 0, m_press = 0, m_hold = 0, m_roll = 0;
    bit e_valid1 = 0, e_valid0 = 0;

    always @(posedge clk) begin
        logic [15:0] deb_old;
        bit tick_old, tick_new, rep;
        int nz, kk;
        if (RST) begin
            m_s1 = '1; m_s2 = '1; m_samp = '1; m_deb = '1;
            m_div = 0; m_run = 1; m_code = 0; m_ticks = 0;
            m_armed = 0; m_press = 0; m_hold = 0; m_roll = 0;
        end else begin
            tick_old = (m_div == SD - 1);
            deb_old  = m_deb;
            nz = zeros(deb_old);
            kk = zero_idx(deb_old);
            if (m_press) begin
                m_press = 0; m_hold = 1; m_ticks = 0;
            end else if (m_hold) begin
                if (nz == 0) m_hold = 0;
                else if (nz > 1 || kk != m_code) begin
                    m_hold = 0; m_roll = 1;
                end else if (tick_old) m_ticks++;
            end else if (m_roll) begin
                if (nz == 0) m_roll = 0;
            end else if (m_armed) begin
                if (nz == 1) begin m_press = 1; m_code = kk; end
                else if (nz > 1) m_roll = 1;
            end
            if (tick_old) begin
                m_run  = (m_s2 == m_samp) ? m_run + 1 : 1;
                m_samp = m_s2;
                if (m_run >= DC) begin
                    m_deb = m_s2;
                    if (&m_s2) m_armed = 1;
                end
            end
            m_s2  = m_s1;
            m_s1  = key_n;
            m_div = (m_div + 1) % SD;
        end
        tick_new = (m_div == SD - 1);
        rep = m_hold && tick_new && zeros(m_deb) == 1 &&
              zero_idx(m_deb) == m_code && due(m_ticks + 1);
        e_valid1 = m_press || rep;
        e_valid0 = m_press;
    end

    always @(negedge clk) begin
        if (valid1 === 1'b1) sc1++;
        if (valid0 === 1'b1) sc0++;
        if (chk_en) begin
            chk("valid", valid1, e_valid1);
            chk("down", down1, m_hold);
            chk("multi", multi1, m_roll);
            chk("code", code1, m_code);
            chk("valid_nr", valid0, e_valid0);
            chk("down_nr", down0, m_hold);
            chk("multi_nr", multi0, m_roll);
            chk("code_nr", code0, m_code);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_strobe(input string tag, input int maxc);
        bit seen;
        seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            cyc(1);
            seen = (valid1 === 1'b1);
        end
        chk(tag, seen, 1);
    endtask

    int s1, s0, lat;

    initial begin
        cyc(3);
        chk_en = 1'b1;
        chk("rst_code", code1, 0);
        chk("rst_valid", valid1, 0);
        chk("rst_down", down1, 0);
        chk("rst_multi", multi1, 0);
        RST = 1'b0;
        cyc(20);

        // single press, latency and level
        s1 = sc1; lat = -1;
        key_n = 16'hFFDF;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (valid1 === 1'b1 && lat < 0) lat = i;
        end
        chk("s1_latency", (lat > 0 && lat <= 20), 1);
        chk("s1_count", sc1 - s1, 1);
        chk("s1_code", code1, 5);
        chk("s1_down", down1, 1);
        key_n = 16'hFFFF;
        cyc(30);
        chk("s1_release", down1, 0);

        // bounce shorter than the filter
        s1 = sc1; s0 = sc0;
        for (int i = 0; i < 20; i++) begin
            key_n[5] = ~key_n[5];
            cyc(SD);
        end
        key_n = 16'hFFFF;
        cyc(30);
        chk("s2_count", sc1 - s1, 0);
        chk("s2_count_nr", sc0 - s0, 0);
        chk("s2_down", down1, 0);

        // auto-repeat schedule
        s0 = sc0;
        key_n = 16'hFDFF;
        wait_strobe("s3_press", 30);
        s1 = sc1;
        cyc(48);
        chk("s3_repeats", sc1 - s1, 4);
        chk("s3_code", code1, 9);
        key_n = 16'hFFFF;
        cyc(40);
        chk("s3_norepeat", sc0 - s0, 1);

        // roll-over
        key_n = 16'hFFFB;
        wait_strobe("s4_press", 30);
        chk("s4_code2", code1, 2);
        cyc(4);
        s1 = sc1;
        key_n = 16'hFF7B;
        cyc(30);
        chk("s4_multi", multi1, 1);
        key_n = 16'hFF7F;
        cyc(30);
        chk("s4_multi_held", multi1, 1);
        chk("s4_count", sc1 - s1, 0);
        key_n = 16'hFFFF;
        cyc(30);
        chk("s4_multi_clr", multi1, 0);
        key_n = 16'hFF7F;
        wait_strobe("s4_press7", 30);
        chk("s4_code7", code1, 7);
        key_n = 16'hFFFF;
        cyc(40);

        // reset while held
        key_n = 16'h7FFF;
        wait_strobe("s5_press", 30);
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        chk("s5_rst_code", code1, 0);
        chk("s5_rst_down", down1, 0);
        s1 = sc1;
        cyc(60);
        chk("s5_held_count", sc1 - s1, 0);
        chk("s5_held_down", down1, 0);
        key_n = 16'hFFFF;
        cyc(30);
        key_n = 16'h7FFF;
        wait_strobe("s5_repress", 30);
        chk("s5_code", code1, 15);
        key_n = 16'hFFFF;
        cyc(40);

        // filter boundary
        s1 = sc1;
        key_n = 16'hFFFE;
        cyc((DC - 1) * SD);
        key_n = 16'hFFFF;
        cyc(40);
        chk("s6_short", sc1 - s1, 0);
        key_n = 16'hFFFE;
        cyc(DC * SD);
        key_n = 16'hFFFF;
        cyc(40);
        chk("s6_exact", sc1 - s1, 1);
        chk("s6_code", code1, 0);

        // random traffic
        for (int it = 0; it < 300; it++) begin
            int r;
            r = $urandom_range(0, 99);
            key_n = 16'hFFFF;
            if (r < 50) begin
                key_n[$urandom_range(0, 15)] = 1'b0;
            end else if (r < 70) begin
                key_n[$urandom_range(0, 15)] = 1'b0;
                key_n[$urandom_range(0, 15)] = 1'b0;
            end
            if ($urandom_range(0, 39) == 0) begin
                RST = 1'b1;
                cyc(1);
                RST = 1'b0;
            end
            cyc($urandom_range(1, 40));
        end
        key_n = 16'hFFFF;
        cyc(40);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
